// File: rtl/mem_master.sv
// Initiator for a single-port memory with a one-cycle registered read latency.
// Issues single writes and incrementing read bursts, and rejects out-of-range requests.
module mem_master #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MEM_DEPTH = 1024,
  parameter int LEN_W     = 3
) (
  input  logic              CLK,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [LEN_W-1:0]  req_len,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              resp_last,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] Data_in,
  input  logic [DATA_W-1:0] Data_out
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR    = 3'd1,
    ST_RD    = 3'd2,
    ST_DRAIN = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(MEM_DEPTH);

  state_t            state_r, state_s;
  logic              mem_read_r, mem_read_s;
  logic              mem_write_r, mem_write_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [DATA_W-1:0] data_in_r, data_in_s;
  logic [LEN_W-1:0]  remain_r, remain_s;
  logic              pend_r, pend_s;
  logic              pend_last_r, pend_last_s;
  logic              resp_valid_r, resp_valid_s;
  logic [DATA_W-1:0] resp_rdata_r, resp_rdata_s;
  logic              resp_err_r, resp_err_s;
  logic              resp_last_r, resp_last_s;
  logic [ADDR_W:0]   end_addr_s;
  logic              range_err_s;
  logic              accept_s;

  assign req_ready   = (state_r == ST_IDLE);
  assign accept_s    = req_valid && req_ready;
  // Extra bit on the end address so a burst can never wrap back into range.
  assign end_addr_s  = {1'b0, req_addr} + (ADDR_W+1)'(req_len);
  assign range_err_s = ({1'b0, req_addr} >= DEPTH_C) ||
                       (!req_write && (end_addr_s >= DEPTH_C));

  assign MemRead    = mem_read_r;
  assign MemWrite   = mem_write_r;
  assign ADDR       = addr_r;
  assign Data_in    = data_in_r;
  assign resp_valid = resp_valid_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_err   = resp_err_r;
  assign resp_last  = resp_last_r;

  // Next-state, strobe and response decode.
  always_comb begin
    state_s      = state_r;
    mem_read_s   = 1'b0;
    mem_write_s  = 1'b0;
    addr_s       = addr_r;
    data_in_s    = data_in_r;
    remain_s     = remain_r;
    pend_s       = mem_read_r;
    pend_last_s  = mem_read_r && (state_r == ST_RD) && (remain_r == LEN_W'(0));
    resp_valid_s = 1'b0;
    resp_rdata_s = {DATA_W{1'b0}};
    resp_err_s   = 1'b0;
    resp_last_s  = 1'b0;

    if (pend_r) begin
      resp_valid_s = 1'b1;
      resp_rdata_s = Data_out;
      resp_last_s  = pend_last_r;
    end else begin
      resp_valid_s = 1'b0;
    end

    case (state_r)
      ST_IDLE: begin
        if (!accept_s) begin
          state_s = ST_IDLE;
        end else if (range_err_s) begin
          state_s = ST_ERR;
        end else if (req_write) begin
          state_s     = ST_WR;
          mem_write_s = 1'b1;
          addr_s      = req_addr;
          data_in_s   = req_wdata;
        end else begin
          state_s    = ST_RD;
          mem_read_s = 1'b1;
          addr_s     = req_addr;
          remain_s   = req_len;
        end
      end
      ST_WR: begin
        state_s      = ST_IDLE;
        resp_valid_s = 1'b1;
        resp_last_s  = 1'b1;
      end
      ST_RD: begin
        if (remain_r != LEN_W'(0)) begin
          mem_read_s = 1'b1;
          addr_s     = addr_r + ADDR_W'(1);
          remain_s   = remain_r - LEN_W'(1);
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        state_s = ST_IDLE;
      end
      ST_ERR: begin
        state_s      = ST_IDLE;
        resp_valid_s = 1'b1;
        resp_err_s   = 1'b1;
        resp_last_s  = 1'b1;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops strobes and any in-flight response.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_r      <= ST_IDLE;
      mem_read_r   <= 1'b0;
      mem_write_r  <= 1'b0;
      addr_r       <= {ADDR_W{1'b0}};
      data_in_r    <= {DATA_W{1'b0}};
      remain_r     <= {LEN_W{1'b0}};
      pend_r       <= 1'b0;
      pend_last_r  <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= {DATA_W{1'b0}};
      resp_err_r   <= 1'b0;
      resp_last_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      mem_read_r   <= mem_read_s;
      mem_write_r  <= mem_write_s;
      addr_r       <= addr_s;
      data_in_r    <= data_in_s;
      remain_r     <= remain_s;
      pend_r       <= pend_s;
      pend_last_r  <= pend_last_s;
      resp_valid_r <= resp_valid_s;
      resp_rdata_r <= resp_rdata_s;
      resp_err_r   <= resp_err_s;
      resp_last_r  <= resp_last_s;
    end
  end

endmodule

// File: tb/tb_mem_master.sv
// Bench for mem_master: behavioural memory plus a transaction-level reference
// that predicts strobes and responses cycle by cycle from the request alone.
module tb_mem_master;
  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int DEPTH = 1024;
  localparam int LW    = 3;

  logic          CLK = 1'b0;
  logic          resetn;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [LW-1:0] req_len;
  logic          resp_valid, resp_err, resp_last;
  logic [DW-1:0] resp_rdata;
  logic          MemRead, MemWrite;
  logic [AW-1:0] ADDR;
  logic [DW-1:0] Data_in, Data_out;

  logic          init_en;
  logic [AW-1:0] init_idx;
  logic [DW-1:0] init_val;
  logic [DW-1:0] mem     [0:DEPTH-1];
  logic [DW-1:0] ref_mem [0:DEPTH-1];

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  mem_master #(.ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH), .LEN_W(LW)) dut (
    .CLK(CLK), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .resp_last(resp_last), .MemRead(MemRead), .MemWrite(MemWrite),
    .ADDR(ADDR), .Data_in(Data_in), .Data_out(Data_out)
  );

  // Single-port memory with registered read data.
  always @(posedge CLK) begin
    if (init_en) begin
      mem[init_idx[9:0]] <= init_val;
    end else begin
      if (MemRead && (ADDR < AW'(DEPTH))) Data_out <= mem[ADDR[9:0]];
      if (MemWrite && (ADDR < AW'(DEPTH))) mem[ADDR[9:0]] <= Data_in;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One request; expectations follow from the request and the reference memory.
  task automatic do_req(input logic wr, input int a, input logic [DW-1:0] d, input int len);
    int  guard, n, k0, k1;
    bit  is_err, is_rd, exp_mr, exp_mw, exp_rv;
    logic [DW-1:0] exp_d;
    guard = 0;
    @(negedge CLK);
    while (!req_ready && guard < 50) begin
      @(negedge CLK);
      guard++;
    end
    check_val("idle_wait", {31'd0, req_ready}, 32'd1);
    is_err = (a >= DEPTH) || (!wr && (a + len) >= DEPTH);
    is_rd  = !wr && !is_err;
    n      = is_rd ? len + 1 : 1;
    k0     = is_rd ? 2 : 1;
    k1     = k0 + n - 1;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a[AW-1:0];
    req_wdata = d;
    req_len   = len[LW-1:0];
    @(posedge CLK); #1;
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = AW'($urandom);
    req_wdata = DW'($urandom);
    for (int k = 0; k <= k1 + 2; k++) begin
      if (k > 0) begin
        @(posedge CLK); #1;
      end
      exp_mr = is_rd && (k < n);
      exp_mw = wr && !is_err && (k == 0);
      exp_rv = (k >= k0) && (k <= k1);
      check_val($sformatf("MemRead@%0d a=%0d", k, a), {31'd0, MemRead}, {31'd0, exp_mr});
      check_val($sformatf("MemWrite@%0d a=%0d", k, a), {31'd0, MemWrite}, {31'd0, exp_mw});
      check_val($sformatf("req_ready@%0d", k), {31'd0, req_ready}, {31'd0, (k >= k1)});
      check_val($sformatf("resp_valid@%0d a=%0d", k, a), {31'd0, resp_valid}, {31'd0, exp_rv});
      if (exp_mr) check_val($sformatf("ADDR_rd@%0d", k), {16'd0, ADDR}, 32'(a + k));
      if (exp_mw) begin
        check_val("ADDR_wr", {16'd0, ADDR}, 32'(a));
        check_val("Data_in", {16'd0, Data_in}, {16'd0, d});
      end
      if (exp_rv) begin
        exp_d = is_rd ? ref_mem[a + k - k0] : {DW{1'b0}};
        check_val($sformatf("resp_err@%0d", k), {31'd0, resp_err}, {31'd0, is_err});
        check_val($sformatf("resp_last@%0d", k), {31'd0, resp_last}, {31'd0, (k == k1)});
        check_val($sformatf("resp_rdata@%0d a=%0d", k, a), {16'd0, resp_rdata}, {16'd0, exp_d});
      end
    end
    if (wr && !is_err) ref_mem[a] = d;
  endtask

  initial begin
    int first_mw, overlap, n_resp, sel, a, ln;
    resetn    = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_len   = '0;
    init_en   = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      init_idx   = AW'(i);
      init_val   = DW'(i * 40503 + 7);
      ref_mem[i] = init_val;
      @(negedge CLK);
    end
    init_en = 1'b0;

    check_val("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check_val("rst_MemRead", {31'd0, MemRead}, 32'd0);
    check_val("rst_MemWrite", {31'd0, MemWrite}, 32'd0);
    check_val("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check_val("rst_ADDR", {16'd0, ADDR}, 32'd0);
    check_val("rst_Data_in", {16'd0, Data_in}, 32'd0);
    check_val("rst_resp_rdata", {16'd0, resp_rdata}, 32'd0);
    check_val("rst_resp_err", {31'd0, resp_err}, 32'd0);
    check_val("rst_resp_last", {31'd0, resp_last}, 32'd0);
    @(negedge CLK);
    resetn = 1'b1;

    do_req(1'b1, 'h1E, 16'd69, 0);
    do_req(1'b0, 'h1E, 16'd0, 0);
    do_req(1'b1, 0, 16'h27E7, 0);
    do_req(1'b1, 1, 16'h27E7, 0);
    do_req(1'b1, 2, 16'h246C, 0);
    do_req(1'b1, 3, 16'h4881, 0);
    do_req(1'b0, 0, 16'd0, 3);
    do_req(1'b0, 1023, 16'd0, 0);
    do_req(1'b0, 1023, 16'd0, 1);
    do_req(1'b1, 'h400, 16'h1111, 0);

    // Write held valid through a burst must wait for req_ready.
    @(negedge CLK);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 16'd0;
    req_len   = 3'd3;
    @(posedge CLK); #1;
    req_write = 1'b1;
    req_addr  = 16'd5;
    req_wdata = 16'hBEEF;
    first_mw  = -1;
    overlap   = 0;
    n_resp    = 0;
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) begin
        @(posedge CLK); #1;
      end
      if (MemWrite && first_mw < 0) begin
        first_mw  = k;
        req_valid = 1'b0;
      end
      if (MemRead && MemWrite) overlap++;
      if (resp_valid) n_resp++;
    end
    req_valid = 1'b0;
    check_val("busy_first_MemWrite", 32'(first_mw), 32'd6);
    check_val("busy_strobe_overlap", 32'(overlap), 32'd0);
    check_val("busy_resp_count", 32'(n_resp), 32'd5);
    ref_mem[5] = 16'hBEEF;
    do_req(1'b0, 5, 16'd0, 0);

    // Asynchronous reset in the second cycle of a len-7 burst.
    @(negedge CLK);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 16'd8;
    req_len   = 3'd7;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    @(posedge CLK); #2;
    check_val("pre_rst_MemRead", {31'd0, MemRead}, 32'd1);
    check_val("pre_rst_ADDR", {16'd0, ADDR}, 32'd9);
    resetn = 1'b0;
    #1;
    check_val("async_rst_MemRead", {31'd0, MemRead}, 32'd0);
    check_val("async_rst_ADDR", {16'd0, ADDR}, 32'd0);
    check_val("async_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check_val("async_rst_req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge CLK);
    @(negedge CLK);
    resetn = 1'b1;
    n_resp = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge CLK); #1;
      if (resp_valid || MemRead) n_resp++;
    end
    check_val("post_rst_quiet", 32'(n_resp), 32'd0);
    do_req(1'b0, 8, 16'd0, 7);

    for (int t = 0; t < 80; t++) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        0:       a = int'($urandom_range(0, 63));
        1:       a = int'($urandom_range(1016, 1023));
        2:       a = int'($urandom_range(1024, 1030));
        default: a = int'($urandom_range(0, 65535));
      endcase
      ln = int'($urandom_range(0, 7));
      do_req(1'($urandom_range(0, 2) == 0), a, DW'($urandom), ln);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_master.md
Name: mem_master

Overview:
- Initiator side of the CPU's single-port memory interface (MemRead/MemWrite/ADDR/Data_in/Data_out).
- Accepts load/store requests from the core over a valid/ready handshake, drives the memory strobes and address, and absorbs the memory's one-cycle registered read latency.
- Returns read data or write acknowledges on a response strobe.
- Supports single writes and incrementing read bursts, and rejects out-of-range addresses without touching memory.

Parameters:
- ADDR_W, 16: address width, word addressed.
- DATA_W, 16: data word width.
- MEM_DEPTH, 1024: number of implemented memory words; valid addresses are 0..MEM_DEPTH-1.
- LEN_W, 3: burst length field width; a read burst is req_len+1 words, so 1..8 words.

Ports:
- CLK  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1=write, 0=read.
- req_addr  in  ADDR_W  start address.
- req_wdata  in  DATA_W  write data.
- req_len  in  LEN_W  read burst length minus 1; ignored for writes.
- resp_valid  out  1  one-cycle response strobe per word or per write ack.
- resp_rdata  out  DATA_W  read data; 0 for write acks and errors.
- resp_err  out  1  qualifies resp_valid; request rejected.
- resp_last  out  1  qualifies resp_valid; final response of the request.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- ADDR  out  ADDR_W  memory address.
- Data_in  out  DATA_W  write data to memory.
- Data_out  in  DATA_W  memory read data; valid the cycle after MemRead is sampled.

Behaviour:
- Reset (resetn=0, asynchronous):
  - State=IDLE, all outputs 0 except req_ready=1.
  - MemRead and MemWrite drop immediately, including mid-burst.
  - No response is issued for an aborted request.
- Register rules: all outputs are registered except req_ready, which is decoded from state (1 only in IDLE).
- Acceptance: at a rising edge where req_valid & req_ready.
- Range check at acceptance: error if req_addr >= MEM_DEPTH, or for reads if req_addr + req_len >= MEM_DEPTH.
  - The sum is computed at ADDR_W+1 bits; no address wrap is ever generated.
- IDLE: on acceptance, go to one of:
  - ERR if the range check fails.
  - WR if req_write=1: MemWrite=1, ADDR=req_addr, Data_in=req_wdata.
  - RD otherwise: MemRead=1, ADDR=req_addr, remaining counter=req_len.
- WR: MemWrite high for exactly one cycle, so memory writes at the next edge.
  - At that edge: MemWrite=0, resp_valid=1, resp_last=1, resp_err=0, resp_rdata=0, go IDLE.
  - Write ack appears 1 cycle after the acceptance edge.
- RD: MemRead is held high for req_len+1 consecutive cycles.
  - Each edge with remaining>0: ADDR+=1, remaining-=1.
  - Edge with remaining=0: MemRead=0, go DRAIN.
- Read data pipeline:
  - A 1-bit pending flag records that MemRead was high in the previous cycle.
  - At each edge where the flag is set: resp_rdata<=Data_out, resp_valid<=1.
  - resp_last is set on the word matching the final issued address.
- DRAIN: one cycle; at its end the last word is captured and the block goes IDLE.
- Read latency: the first word's resp_valid is high 2 cycles after the acceptance edge.
  - A burst of N words yields N consecutive resp_valid cycles with ascending addresses.
  - req_ready returns high in the same cycle as the last resp_valid.
- ERR: no memory strobes.
  - Next edge: resp_valid=1, resp_err=1, resp_last=1, resp_rdata=0, go IDLE.
  - Latency 1 cycle.
- Strobe exclusivity: MemRead and MemWrite are never high together.
- Backpressure: responses have none; the core must always accept resp_valid.
- Busy: req_valid while not IDLE is ignored; no queueing, and the request is not captured.
- resp_valid is a one-cycle pulse per word; it deasserts when no capture occurs.

Test Plan:
- Write: write addr 0x001E data 69 -> MemWrite=1 for exactly 1 cycle with ADDR=0x001E, Data_in=69; ack resp_valid/resp_last 1 cycle after acceptance.
- Read-back: read 0x001E len 0 -> MemRead 1 cycle; resp_rdata=69, resp_last=1 two cycles after acceptance; req_ready high that cycle.
- Burst: preload mem[0..3]=0x27E7,0x27E7,0x246C,0x4881; read addr 0 len 3 -> MemRead high 4 cycles with ADDR 0,1,2,3; 4 consecutive resp_valid with those values; resp_last only on the 4th.
- Range check: read 1023 len 0 -> data returned, no error. Read 1023 len 1 -> resp_err=1 after 1 cycle, no MemRead pulse. Write 0x0400 -> resp_err=1, no MemWrite.
- Busy and back-to-back: req_valid held during a burst -> ignored until req_ready; a write issued on the cycle req_ready returns -> MemWrite 1 cycle later, no strobe overlap.
- Reset mid-operation: resetn low during the 2nd cycle of a len-7 burst -> MemRead, resp_valid, ADDR go 0 asynchronously; after release, req_ready=1 and a new read completes normally.
